// File: rtl/fetch_pc_unit_if.sv
// ============================================================================
// Module   : fetch_pc_unit_if
// Brief    : Memory-side and decode-side signal bundle of the fetch PC unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_pc_unit_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_instr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        id_valid;
    logic        misalign_err;
    logic [31:0] fetch_count;

    modport master (
        output mem_addr,
        input  mem_instr,
        input  stall,
        input  redirect,
        input  redirect_target,
        output id_instr,
        output id_pc,
        output id_pc_plus4,
        output id_valid,
        output misalign_err,
        output fetch_count
    );

    modport slave (
        input  mem_addr,
        output mem_instr,
        output stall,
        output redirect,
        output redirect_target,
        input  id_instr,
        input  id_pc,
        input  id_pc_plus4,
        input  id_valid,
        input  misalign_err,
        input  fetch_count
    );
endinterface

`default_nettype wire

// File: rtl/fetch_pc_unit.sv
// ============================================================================
// Module   : fetch_pc_unit
// Brief    : Program counter and instruction-fetch alignment front end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  wire          clk,
    input  wire          rst,
    fetch_pc_unit_if.master bus
);

    localparam logic [31:0] c_WORD_BYTES = 32'd4;

    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic        r_req_valid;
    logic        r_misalign;
    logic [31:0] r_fetch_count;

    logic [31:0] w_target;
    logic        w_target_misaligned;
    logic [31:0] w_mem_addr;

    assign w_target            = {bus.redirect_target[31:2], 2'b00};
    assign w_target_misaligned = (bus.redirect_target[1:0] != 2'b00);

    // Stall replays req_pc so the returning word stays paired with id_pc.
    always_comb begin
        w_mem_addr = r_pc;
        if (bus.redirect) begin
            w_mem_addr = w_target;
        end else if (bus.stall) begin
            w_mem_addr = r_req_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_req_pc      <= RESET_PC;
            r_req_valid   <= 1'b0;
            r_misalign    <= 1'b0;
            r_fetch_count <= 32'd0;
        end else begin
            if (bus.redirect) begin
                r_req_pc    <= w_target;
                r_req_valid <= 1'b1;
                r_pc        <= w_target + c_WORD_BYTES;
                r_misalign  <= r_misalign | w_target_misaligned;
            end else if (!bus.stall) begin
                r_req_pc    <= r_pc;
                r_req_valid <= 1'b1;
                r_pc        <= r_pc + c_WORD_BYTES;
            end
            if (r_req_valid && !bus.stall) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    assign bus.mem_addr     = w_mem_addr;
    assign bus.id_instr     = r_req_valid ? bus.mem_instr : NOP_WORD;
    assign bus.id_pc        = r_req_pc;
    assign bus.id_pc_plus4  = r_req_pc + c_WORD_BYTES;
    assign bus.id_valid     = r_req_valid;
    assign bus.misalign_err = r_misalign;
    assign bus.fetch_count  = r_fetch_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
// ============================================================================
// Module   : tb_fetch_pc_unit
// Brief    : Directed self-checking bench for fetch_pc_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_pc_unit;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    fetch_pc_unit_if bus ();

    fetch_pc_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_WORD (32'h0000_0000)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0: mem_word = 32'h1111_1111;
            32'h4: mem_word = 32'h2222_2222;
            32'h8: mem_word = 32'h3333_3333;
            default: mem_word = a ^ 32'hA5A5_5A5A;
        endcase
    endfunction

    // Instruction memory with one cycle of read latency.
    always @(posedge clk) bus.mem_instr <= mem_word(bus.mem_addr);

    // Behavioural expectation: which address decode should be looking at now.
    logic [31:0] m_pc, m_next, m_count, seen_addr;
    logic        m_valid, m_err;

    task automatic model_reset();
        m_pc = 32'h0; m_next = 32'h0; m_valid = 1'b0; m_count = 32'h0; m_err = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    task automatic check_bundle();
        chk("id_valid", {31'd0, bus.id_valid}, {31'd0, m_valid});
        chk("id_pc", bus.id_pc, m_pc);
        chk("id_pc_plus4", bus.id_pc_plus4, m_pc + 32'd4);
        chk("id_instr", bus.id_instr, m_valid ? mem_word(m_pc) : 32'h0);
        chk("fetch_count", bus.fetch_count, m_count);
        chk("misalign_err", {31'd0, bus.misalign_err}, {31'd0, m_err});
    endtask

    // One clock: drive inputs, check the address, advance the model, check the bundle.
    task automatic tick(input logic st, input logic rd, input logic [31:0] tgt);
        logic [31:0] aligned;
        bus.stall = st; bus.redirect = rd; bus.redirect_target = tgt;
        aligned = {tgt[31:2], 2'b00};
        #1;
        seen_addr = bus.mem_addr;
        chk("mem_addr", bus.mem_addr, rd ? aligned : (st ? m_pc : m_next));
        if (m_valid && !st) m_count = m_count + 32'd1;
        if (rd) begin
            m_pc = aligned; m_next = aligned + 32'd4; m_valid = 1'b1;
            m_err = m_err | (tgt[1:0] != 2'b00);
        end else if (!st) begin
            m_pc = m_next; m_next = m_next + 32'd4; m_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        check_bundle();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] held;
        n_pass = 0; n_total = 0;
        rst = 1'b1; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_target = 32'h0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        chk("rst mem_addr", bus.mem_addr, 32'h0);
        chk("rst id_pc_plus4", bus.id_pc_plus4, 32'h4);
        check_bundle();

        rst = 1'b0;
        #1;
        chk("first valid", {31'd0, bus.id_valid}, 32'd0);
        chk("first instr", bus.id_instr, 32'h0);
        tick(0, 0, 0); chk("seq0 instr", bus.id_instr, 32'h1111_1111); chk("seq0 pc", bus.id_pc, 32'h0);
        tick(0, 0, 0); chk("seq1 instr", bus.id_instr, 32'h2222_2222); chk("seq1 pc", bus.id_pc, 32'h4);
        tick(0, 0, 0); chk("seq2 instr", bus.id_instr, 32'h3333_3333); chk("seq2 pc", bus.id_pc, 32'h8);
        tick(0, 0, 0); chk("count after 3", bus.fetch_count, 32'd3);

        // Return to address 4 then stall there.
        tick(0, 1, 32'h4); chk("back to 4", bus.id_pc, 32'h4);
        held = bus.fetch_count;
        chk("count before stall", held, 32'd4);
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 0);
            chk("stall mem_addr", seen_addr, 32'h4);
            chk("stall instr", bus.id_instr, 32'h2222_2222);
            chk("stall pc", bus.id_pc, 32'h4);
            chk("stall count", bus.fetch_count, held);
        end
        tick(0, 0, 0); chk("post stall pc", bus.id_pc, 32'h8);

        tick(0, 1, 32'h40);
        chk("redir mem_addr", seen_addr, 32'h40);
        chk("redir pc", bus.id_pc, 32'h40);
        chk("redir pc4", bus.id_pc_plus4, 32'h44);
        tick(0, 0, 0); chk("redir next pc", bus.id_pc, 32'h44);

        tick(1, 1, 32'h80);
        chk("stall+redir pc", bus.id_pc, 32'h80);
        chk("stall+redir valid", {31'd0, bus.id_valid}, 32'd1);

        tick(0, 1, 32'h46);
        chk("misalign mem_addr", seen_addr, 32'h44);
        chk("misalign pc", bus.id_pc, 32'h44);
        chk("misalign err", {31'd0, bus.misalign_err}, 32'd1);
        for (int i = 0; i < 10; i++) tick(0, 0, 0);
        chk("err sticky", {31'd0, bus.misalign_err}, 32'd1);

        tick(0, 1, 32'hFFFF_FFFC);
        chk("wrap pc4", bus.id_pc_plus4, 32'h0);
        tick(0, 0, 0); chk("wrap pc", bus.id_pc, 32'h0);
        tick(1, 0, 0);

        // Asynchronous reset pulse between clock edges.
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("async valid", {31'd0, bus.id_valid}, 32'd0);
        chk("async count", bus.fetch_count, 32'd0);
        chk("async err", {31'd0, bus.misalign_err}, 32'd0);
        bus.stall = 1'b0;
        #1;
        chk("async mem_addr", bus.mem_addr, 32'h0);
        check_bundle();
        rst = 1'b0;
        tick(0, 0, 0);
        chk("after reset pc", bus.id_pc, 32'h0);
        chk("after reset instr", bus.id_instr, 32'h1111_1111);
        tick(0, 0, 0); tick(0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch front end directly upstream of the instruction memory.
- Owns the program counter and drives the byte address to the memory.
- Aligns the memory's one-cycle-registered instruction word with the PC that produced it, and presents an {instruction, pc, pc+4, valid} bundle to decode.
- Handles decode stalls (by replaying the address) and branch/jump redirects from later stages.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset; must be word-aligned.
- NOP_WORD, 32'h0000_0000: value driven on id_instr when id_valid=0.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_addr  out  32  byte address to the instruction memory; the word appears on mem_instr one clock later.
- mem_instr  in  32  registered instruction word returned by the memory.
- stall  in  1  decode cannot accept; hold the current id_* bundle.
- redirect  in  1  taken branch/jump; refetch from redirect_target.
- redirect_target  in  32  new PC (byte address).
- id_instr  out  32  instruction for decode.
- id_pc  out  32  address of id_instr.
- id_pc_plus4  out  32  id_pc + 4, modulo 2^32.
- id_valid  out  1  id_* bundle is a real fetched instruction.
- misalign_err  out  1  sticky; set when a redirect target has bit1 or bit0 set.
- fetch_count  out  32  number of instructions delivered to decode.

Behaviour:
- Registers:
  - pc_q: next sequential address.
  - req_pc: address whose word is on mem_instr this cycle.
  - req_valid.
  - misalign_err.
  - fetch_count.
- Reset (async, rst=1):
  - pc_q=RESET_PC, req_pc=RESET_PC, req_valid=0, misalign_err=0, fetch_count=0.
  - Outputs during reset: id_valid=0, id_instr=NOP_WORD, id_pc=RESET_PC, id_pc_plus4=RESET_PC+4, mem_addr=RESET_PC.
- Outputs (combinational from registers and mem_instr):
  - id_instr = req_valid ? mem_instr : NOP_WORD.
  - id_pc = req_pc.
  - id_pc_plus4 = req_pc + 4.
  - id_valid = req_valid.
- Address mux, in priority order:
  - redirect=1: mem_addr = {redirect_target[31:2], 2'b00}.
  - else stall=1: mem_addr = req_pc (replay, so mem_instr stays aligned with req_pc).
  - else: mem_addr = pc_q.
- Register updates each edge, in priority order:
  - redirect: req_pc <= aligned target; req_valid <= 1; pc_q <= aligned target + 4; misalign_err <= misalign_err | (redirect_target[1:0] != 0).
  - stall (no redirect): pc_q, req_pc, req_valid hold.
  - else: req_pc <= pc_q; req_valid <= 1; pc_q <= pc_q + 4.
- Redirect overrides stall in the same cycle. The bundle shown in the redirect cycle is wrong-path; discarding it is decode's responsibility.
- fetch_count increments by 1 on every edge with req_valid=1 and stall=0, including redirect cycles. It wraps 2^32-1 -> 0.
- Wrap-around: pc_q = 32'hFFFF_FFFC advances to 0; id_pc_plus4 wraps the same way. No error is flagged.
- Latency:
  - First valid bundle appears in the cycle after reset deassertion, i.e. one edge after reset release.
  - Redirect-to-target bundle also appears after one edge (target address is bypassed onto mem_addr in the redirect cycle).
- Stall of any length: id_* outputs stay bit-identical, mem_addr = req_pc, fetch_count frozen.
- Reset asserted mid-stall or mid-redirect: immediate return to reset values; no pending redirect survives.
- misalign_err clears only on rst.

Test Plan:
- Reset sequencing: RESET_PC=0, memory words 0x11111111@0, 0x22222222@4, 0x33333333@8. Release rst, no stall. Required:
  - First cycle: id_valid=0, id_instr=0.
  - Next three cycles: id_instr = 0x11111111 / 0x22222222 / 0x33333333 with id_pc = 0 / 4 / 8.
  - fetch_count = 3 after those cycles.
- Stall: assert stall for 3 cycles while id_pc=4. Required:
  - id_instr=0x22222222, id_pc=4, mem_addr=4, fetch_count unchanged throughout.
  - One cycle after release, id_pc=8.
- Redirect: assert redirect with target 0x40 while id_pc=8. Required:
  - mem_addr=0x40 that cycle.
  - Next cycle: id_pc=0x40, id_pc_plus4=0x44.
  - Following cycle: id_pc=0x44.
- Redirect during stall: stall=1 and redirect=1 with target 0x80 in the same cycle. Required: next cycle id_pc=0x80, id_valid=1.
- Misaligned target: redirect to 0x46. Required:
  - mem_addr=0x44, then id_pc=0x44.
  - misalign_err=1, still 1 after 10 more cycles.
  - misalign_err=0 only after rst.
- Wrap-around and async reset:
  - Redirect to 0xFFFFFFFC. Required: id_pc_plus4=0, following bundle id_pc=0.
  - Pulse rst between clock edges. Required: id_valid=0, fetch_count=0, misalign_err=0 immediately, without waiting for a clock edge.
